key_cmd_fifo: RTL and testbench
===============================

// Module: key_cmd_fifo
// PURPOSE
// - Command buffer between Keyboard_Decoder (upstream) and Game_Player (downstream), all in the clk_100M domain.
// - Captures 3-bit key commands via the decoder's ready/read_fin handshake and stores them in a FIFO.
// - Re-presents them to Game_Player with the same ready/read_fin protocol, so fast bursts are not lost while the game logic is busy.
// PARAMETERS
// - CMD_WIDTH   3   width of one key command
// - DEPTH       8   FIFO entries; power of 2, >=2
// - LOG2_DEPTH  $clog2(DEPTH)   pointer width
// PORTS
// - clock         in   1           system clock (clk_100M)
// - reset         in   1           synchronous, active-high reset
// - in_ready      in   1           decoder has new command (level)
// - in_data       in   CMD_WIDTH   command from decoder, valid while in_ready=1
// - in_read_fin   out  1           ack to decoder: command captured or dropped
// - out_ready     out  1           command available to Game_Player (level)
// - out_data      out  CMD_WIDTH   FIFO head, valid while out_ready=1
// - out_read_fin  in   1           Game_Player has consumed out_data
// - count         out  LOG2_DEPTH+1  current occupancy, 0..DEPTH
// - overflow      out  1           sticky: a command was dropped while full
// BEHAVIOUR
// - Reset, and a reset asserted mid-transfer: clear both pointers, count=0, out_ready=0, out_data=0, in_read_fin=0, overflow=0, in-FSM->IN_IDLE.
//   - A half-finished upstream handshake is abandoned.
//   - The decoder sees in_read_fin=0 and re-offers any command it still holds.
// - Input FSM, four-phase handshake:
//   - IN_IDLE, in_ready=1: write in_data at wr_ptr if not full; if full, discard it and set overflow=1.
//     Then in_read_fin<=1 and go to IN_ACK.
//   - IN_ACK: hold in_read_fin=1 until in_ready=0, then in_read_fin<=0 and return to IN_IDLE.
//   - Exactly one capture per in_ready high period.
//   - Capture-to-in_read_fin latency: 1 cycle.
// - Output side:
//   - out_ready = (count!=0), registered.
//   - out_data = mem[rd_ptr], registered, updated in the same cycle as out_ready.
//   - Pop on the rising edge of out_read_fin only: sample the previous value, pop when out_read_fin & ~prev & (count!=0).
//   - out_read_fin held high pops one entry, not many.
//   - A rising edge while empty is ignored; no underflow.
//   - After a pop, the next head (or out_ready=0) is visible 1 cycle later.
//   - out_ready toggles low for 1 cycle between back-to-back entries so Game_Player sees a fresh edge.
// - Write-to-out_ready latency, empty FIFO: 2 cycles after in_ready is sampled high.
// - Simultaneous push and pop in one cycle: both performed, count unchanged.
//   - A push while full plus a pop in the same cycle counts as full: the command is dropped.
// - Pointers are LOG2_DEPTH bits and wrap modulo DEPTH.
// - count is updated +1/-1/0 per cycle and never exceeds DEPTH.
// - overflow stays set until reset.
// CONFIGURATION
// - Macro KEY_CMD_REPEAT_FILTER_EN.
// - Defined: an incoming command equal to the most recently accepted command, arriving while that command is still the only entry in the FIFO (count==1, not yet popped), is acked but not stored.
//   - This collapses PS/2 typematic repeats.
//   - The "last accepted" register clears on reset.
// - Undefined: every acked command is stored (subject to full); no extra registers.
// TESTING
// - Reset, then a single command: in_data=3'd2, in_ready high 5 cycles -> in_read_fin high 1 cycle later; out_ready=1 with out_data=2 two cycles after capture; count=1.
// - Burst of 8 distinct commands 0..7, out_read_fin=0 -> count=8, overflow=0.
//   - A 9th command -> acked, overflow=1, count stays 8.
//   - Then 8 pops -> out_data sequence 0..7, then out_ready=0.
// - out_read_fin held high 20 cycles with 3 entries -> exactly one pop, count 3->2.
// - Push and pop in the same cycle with count=4 -> count stays 4 and the FIFO order is preserved across pointer wrap; run 20 mixed operations against a reference queue.
// - reset pulsed while in IN_ACK with 5 entries -> next cycle count=0, out_ready=0, in_read_fin=0, overflow=0.
// - KEY_CMD_REPEAT_FILTER_EN defined: push 3, 3 with no pop -> count=1; pop, then push 3 -> count=1, out_data=3.
//   - Same stimulus with the macro undefined -> count=2 after the first two pushes.

Source files
------------

// File: rtl/key_cmd_fifo_if.sv
// Handshake bundle between Keyboard_Decoder, key_cmd_fifo and Game_Player.
// slave: the FIFO side. master: the side that drives in_ready/in_data and
// out_read_fin (decoder + player, or a testbench standing in for both).
interface key_cmd_fifo_if #(
  parameter int CMD_WIDTH  = 3,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = $clog2(DEPTH)
);
  logic                  in_ready;
  logic [CMD_WIDTH-1:0]  in_data;
  logic                  in_read_fin;
  logic                  out_ready;
  logic [CMD_WIDTH-1:0]  out_data;
  logic                  out_read_fin;
  logic [LOG2_DEPTH:0]   count;
  logic                  overflow;

  modport slave (
    input  in_ready, in_data, out_read_fin,
    output in_read_fin, out_ready, out_data, count, overflow
  );

  modport master (
    output in_ready, in_data, out_read_fin,
    input  in_read_fin, out_ready, out_data, count, overflow
  );
endinterface

// File: rtl/key_cmd_fifo.sv
// key_cmd_fifo: buffers 3-bit key commands between the keyboard decoder and
// the game player. Both sides use a level ready / read_fin handshake.
// Optional macro KEY_CMD_REPEAT_FILTER_EN: drop a command equal to the last
// stored one while that command is still the sole, unpopped entry (collapses
// PS/2 typematic repeats). Undefined by default.
module key_cmd_fifo #(
  parameter int CMD_WIDTH  = 3,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  key_cmd_fifo_if.slave      bus
);
  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);

  typedef enum logic {IN_IDLE, IN_ACK} in_state_t;

  in_state_t             in_state, in_state_nxt;
  logic                  in_fin_q, in_fin_nxt;
  logic [CMD_WIDTH-1:0]  mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG2_DEPTH:0]   count;
  logic                  prev_fin;
  logic                  overflow;
  logic                  out_ready;
  logic [CMD_WIDTH-1:0]  out_data;
  logic                  capture, full, repeat_hit, push, pop, drop;

  // Input handshake: one capture per in_ready high period, ack held until
  // the decoder drops in_ready.
  always_comb begin
    in_state_nxt = in_state;
    in_fin_nxt   = in_fin_q;
    capture      = 1'b0;
    case (in_state)
      IN_IDLE: if (bus.in_ready) begin
        capture      = 1'b1;
        in_fin_nxt   = 1'b1;
        in_state_nxt = IN_ACK;
      end
      IN_ACK: if (!bus.in_ready) begin
        in_fin_nxt   = 1'b0;
        in_state_nxt = IN_IDLE;
      end
      default: begin
        in_fin_nxt   = 1'b0;
        in_state_nxt = IN_IDLE;
      end
    endcase
  end

  // Input FSM state and ack register.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_state <= IN_IDLE;
      in_fin_q <= 1'b0;
    end else begin
      in_state <= in_state_nxt;
      in_fin_q <= in_fin_nxt;
    end
  end

  // Pop only on a rising edge of out_read_fin, and never from an empty FIFO.
  // Fullness is judged before any same-cycle pop, so push+pop while full drops.
  assign full = (count == FULL_CNT);
  assign pop  = bus.out_read_fin & ~prev_fin & (count != '0);

`ifdef KEY_CMD_REPEAT_FILTER_EN
  logic [CMD_WIDTH-1:0] last_cmd;

  // Remember the most recently stored command for repeat suppression.
  always_ff @(posedge clock) begin
    if (reset)     last_cmd <= '0;
    else if (push) last_cmd <= bus.in_data;
  end

  // count==1 means the sole entry is the last stored one; a same-cycle pop
  // means it is being consumed, so the new command is a fresh press.
  assign repeat_hit = (count == (LOG2_DEPTH+1)'(1)) && (bus.in_data == last_cmd) && !pop;
`else
  assign repeat_hit = 1'b0;
`endif

  assign push = capture & ~full & ~repeat_hit;
  assign drop = capture & full;

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Pointers, occupancy, pop edge detector and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prev_fin <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev_fin <= bus.out_read_fin;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Registered head presentation; a pop forces out_ready low for one cycle
  // so the player always sees a fresh rising edge for the next entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_ready <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_ready <= 1'b0;
    end else begin
      out_ready <= (count != '0);
      if (count != '0) out_data <= mem[rd_ptr];
    end
  end

  assign bus.in_read_fin = in_fin_q;
  assign bus.out_ready   = out_ready;
  assign bus.out_data    = out_data;
  assign bus.count       = count;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_key_cmd_fifo.sv
// Directed bench for key_cmd_fifo: a per-cycle vector table for the single
// command handshake, then hand-written multi-cycle sequences.
module tb_key_cmd_fifo;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef KEY_CMD_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  key_cmd_fifo_if #(.CMD_WIDTH(3), .DEPTH(8)) bus ();
  key_cmd_fifo #(.CMD_WIDTH(3), .DEPTH(8)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  typedef struct {
    logic       rdy;
    logic [2:0] din;
    logic       rfin;
    logic       e_fin;
    logic       e_ordy;
    logic [2:0] e_data;
    logic       chk_data;
    int         e_cnt;
  } vec_t;

  vec_t vecs[9];
  int   q[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_ready = 1'b0;
    bus.in_data = 3'd0;
    bus.out_read_fin = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [2:0] d);
    bus.in_ready = 1'b1;
    bus.in_data = d;
    step();
    check("push_ack", int'(bus.in_read_fin), 1);
    bus.in_ready = 1'b0;
    step();
    check("push_ack_drop", int'(bus.in_read_fin), 0);
  endtask

  task automatic pop();
    bus.out_read_fin = 1'b1;
    step();
    bus.out_read_fin = 1'b0;
    step();
  endtask

  initial begin
    int op;
    bit do_push, do_pop, push_ok, pop_ok;
    logic [2:0] d;

    // in_ready, in_data, out_read_fin, exp fin, exp out_ready, exp data, check data, exp count
    vecs[0] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1};
    vecs[1] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1};
    vecs[2] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1};
    vecs[3] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1};
    vecs[4] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1};
    vecs[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1};
    vecs[6] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0};
    vecs[7] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0};
    vecs[8] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0};

    do_reset();
    check("rst_fin",  int'(bus.in_read_fin), 0);
    check("rst_ordy", int'(bus.out_ready), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_cnt",  int'(bus.count), 0);
    check("rst_ovf",  int'(bus.overflow), 0);

    // Single command: in_ready high 5 cycles, then consumed.
    for (int i = 0; i < 9; i++) begin
      bus.in_ready = vecs[i].rdy;
      bus.in_data = vecs[i].din;
      bus.out_read_fin = vecs[i].rfin;
      step();
      check($sformatf("vec%0d_fin", i), int'(bus.in_read_fin), int'(vecs[i].e_fin));
      check($sformatf("vec%0d_ordy", i), int'(bus.out_ready), int'(vecs[i].e_ordy));
      check($sformatf("vec%0d_cnt", i), int'(bus.count), vecs[i].e_cnt);
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), int'(bus.out_data), int'(vecs[i].e_data));
    end

    // Burst 0..7 fills the FIFO; 9th is acked and dropped.
    do_reset();
    for (int i = 0; i < 8; i++) push(3'(i));
    check("burst_cnt", int'(bus.count), 8);
    check("burst_ovf", int'(bus.overflow), 0);
    push(3'd5);
    check("full_cnt", int'(bus.count), 8);
    check("full_ovf", int'(bus.overflow), 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_ordy", i), int'(bus.out_ready), 1);
      check($sformatf("drain%0d_data", i), int'(bus.out_data), i);
      pop();
    end
    check("drain_ordy", int'(bus.out_ready), 0);
    check("drain_cnt", int'(bus.count), 0);
    check("drain_ovf_sticky", int'(bus.overflow), 1);
    pop();
    check("empty_pop_cnt", int'(bus.count), 0);
    check("empty_pop_ordy", int'(bus.out_ready), 0);

    // out_read_fin held high pops exactly one entry.
    do_reset();
    push(3'd1);
    push(3'd2);
    push(3'd3);
    check("hold_pre_cnt", int'(bus.count), 3);
    bus.out_read_fin = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("hold_cnt", int'(bus.count), 2);
    check("hold_ordy", int'(bus.out_ready), 1);
    check("hold_data", int'(bus.out_data), 2);
    bus.out_read_fin = 1'b0;
    step();

    // Simultaneous push+pop at count 4, then mixed ops against a queue.
    push(3'd4);
    push(3'd5);
    q = '{2, 3, 4, 5};
    check("pp_pre_cnt", int'(bus.count), 4);
    bus.in_ready = 1'b1;
    bus.in_data = 3'd6;
    bus.out_read_fin = 1'b1;
    step();
    check("pp_cnt", int'(bus.count), 4);
    bus.in_ready = 1'b0;
    bus.out_read_fin = 1'b0;
    step();
    void'(q.pop_front());
    q.push_back(6);
    check("pp_head", int'(bus.out_data), q[0]);
    for (int i = 0; i < 20; i++) begin
      op = i % 3;
      do_push = (op != 1);
      do_pop = (op != 0);
      d = 3'((i * 3 + 1) % 8);
      pop_ok = do_pop && (q.size() != 0);
      push_ok = do_push && (q.size() < 8);
      bus.in_ready = do_push;
      bus.in_data = d;
      bus.out_read_fin = do_pop;
      step();
      bus.in_ready = 1'b0;
      bus.out_read_fin = 1'b0;
      step();
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(int'(d));
      check($sformatf("mix%0d_cnt", i), int'(bus.count), q.size());
      if (q.size() != 0) begin
        check($sformatf("mix%0d_ordy", i), int'(bus.out_ready), 1);
        check($sformatf("mix%0d_data", i), int'(bus.out_data), q[0]);
      end else begin
        check($sformatf("mix%0d_ordy", i), int'(bus.out_ready), 0);
      end
    end

    // Reset in the middle of an upstream handshake with 5 entries.
    do_reset();
    for (int i = 0; i < 8; i++) push(3'(i));
    push(3'd7);
    for (int i = 0; i < 4; i++) pop();
    bus.in_ready = 1'b1;
    bus.in_data = 3'd1;
    step();
    check("mid_fin", int'(bus.in_read_fin), 1);
    check("mid_cnt", int'(bus.count), 5);
    check("mid_ovf", int'(bus.overflow), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_cnt",  int'(bus.count), 0);
    check("mrst_ordy", int'(bus.out_ready), 0);
    check("mrst_fin",  int'(bus.in_read_fin), 0);
    check("mrst_ovf",  int'(bus.overflow), 0);
    bus.in_ready = 1'b0;
    step();

    // Repeat filter behaviour (or its absence).
    do_reset();
    push(3'd3);
    push(3'd3);
    check("rpt_cnt2", int'(bus.count), FILT ? 1 : 2);
    pop();
    push(3'd3);
    check("rpt_cnt3", int'(bus.count), FILT ? 1 : 2);
    check("rpt_data", int'(bus.out_data), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
